// File: rtl/multiboot_pkg.sv
// multiboot_pkg: state encoding, flash command bytes and
// serial_wb_master frame opcodes shared by the boot manager.
package multiboot_pkg;

  typedef enum logic [2:0] {
    S_PROTECT,
    S_COUNT,
    S_HALT,
    S_BOOT,
    S_UNPROT
  } boot_state_t;

  // serial_wb_master frame opcodes and registers
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] REG_CFG  = 8'h00;
  localparam logic [7:0] REG_DATA = 8'h01;

  // config register values: bit0 = SS high, bit1 = discard rx
  localparam logic [7:0] SS_LOW   = 8'h00;
  localparam logic [7:0] SS_HIGH  = 8'h01;
  localparam logic [7:0] DISCARD  = 8'h02;

  // frame length fields hold (count - 1)
  localparam logic [7:0] LEN_1     = 8'd0;
  localparam logic [7:0] LEN_2     = 8'd1;
  localparam logic [7:0] LEN_DUMMY = 8'd254;

  // flash command bytes
  localparam logic [7:0] ASCII_DIGIT0 = 8'h30;
  localparam logic [7:0] FLASH_RPD    = 8'hAB;
  localparam logic [7:0] FLASH_VWREN  = 8'h50;
  localparam logic [7:0] FLASH_WRSR1  = 8'h01;
  localparam logic [7:0] SR1_PROTECT  = 8'h24;

  localparam int PROT_LEN = 40;

endpackage

// File: rtl/rom_to_axis.sv
// rom_to_axis: plays a constant byte table out as one AXIS packet,
// restarting from the first word whenever held in reset.
module rom_to_axis #(
  parameter int DEPTH = 40,
  parameter logic [8*DEPTH-1:0] CONTENTS = '0
) (
  input  logic       clk,
  input  logic       sresetn,
  input  logic       m_axis_tready,
  output logic       m_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] idx;
  logic          active;
  logic          started;

  // Word pointer advances only on a handshake, so data holds while stalled
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      idx     <= '0;
      active  <= 1'b0;
      started <= 1'b0;
    end else if (!started) begin
      started <= 1'b1;
      active  <= 1'b1;
    end else if (active && m_axis_tready) begin
      if (m_axis_tlast) active <= 1'b0;
      else              idx    <= idx + 1'b1;
    end
  end

  assign m_axis_tvalid = active;
  assign m_axis_tlast  = (idx == AW'(DEPTH - 1));
  assign m_axis_tdata  = CONTENTS[8*(DEPTH-1-int'(idx)) +: 8];

endmodule

// File: rtl/multiboot_manager.sv
// multiboot_manager: flash protection, boot countdown and image pick.
// Define MULTIBOOT_UART_SELECT_EN to allow UART digits to choose an image.
module multiboot_manager
  import multiboot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2**27,
  parameter int NUM_LEDS       = 8,
  parameter int NUM_IMAGES     = 4,
  parameter int DEFAULT_IMAGE  = 1,
  parameter int BLINK_BIT      = 25,
  localparam int IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic                clk,
  input  logic                sresetn,
  input  logic                uart_rx_valid,
  input  logic [7:0]          uart_rx_data,
  input  logic                enable_protection,
  output logic                reboot,
  output logic [IW-1:0]       image_sel,
  output logic [NUM_LEDS-1:0] leds,
  input  logic                m_axis_protect_tready,
  output logic                m_axis_protect_tvalid,
  output logic [7:0]          m_axis_protect_tdata,
  output logic                axis_protect_done
);

  localparam int TW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int CW   = (TW > BLINK_BIT + 1) ? TW : BLINK_BIT + 1;
  localparam int STEP = TIMEOUT_CYCLES / NUM_LEDS;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [8*PROT_LEN-1:0] PROT_ROM = {
    OP_WRITE, REG_CFG,  LEN_1, SS_LOW,
    OP_WRITE, REG_DATA, LEN_1, FLASH_RPD,
    OP_WRITE, REG_CFG,  LEN_1, SS_HIGH | DISCARD,
    OP_READ,  REG_DATA, LEN_DUMMY,
    OP_WRITE, REG_CFG,  LEN_1, SS_LOW,
    OP_WRITE, REG_DATA, LEN_1, FLASH_VWREN,
    OP_WRITE, REG_CFG,  LEN_1, SS_HIGH,
    OP_WRITE, REG_CFG,  LEN_1, SS_LOW,
    OP_WRITE, REG_DATA, LEN_2, FLASH_WRSR1, SR1_PROTECT,
    OP_WRITE, REG_CFG,  LEN_1, SS_HIGH
  };

  boot_state_t   state;
  logic          halt;
  logic [CW-1:0] ctr;
  logic          rom_rstn;
  logic          tlast;
  logic          hs_last;
  logic          pick;
  logic [NUM_LEDS-1:0] bar;

  assign rom_rstn = sresetn && (state == S_PROTECT);
  assign hs_last  = m_axis_protect_tvalid && m_axis_protect_tready && tlast;

  rom_to_axis #(
    .DEPTH    (PROT_LEN),
    .CONTENTS (PROT_ROM)
  ) u_rom (
    .clk           (clk),
    .sresetn       (rom_rstn),
    .m_axis_tready (m_axis_protect_tready),
    .m_axis_tvalid (m_axis_protect_tvalid),
    .m_axis_tdata  (m_axis_protect_tdata),
    .m_axis_tlast  (tlast)
  );

`ifdef MULTIBOOT_UART_SELECT_EN
  logic [7:0]    digit;
  logic [IW-1:0] sel;

  assign digit = uart_rx_data - ASCII_DIGIT0;
  assign pick  = uart_rx_valid && (uart_rx_data >= ASCII_DIGIT0) &&
                 (32'(digit) < NUM_IMAGES);

  // Image choice latches together with the jump to S_BOOT
  always_ff @(posedge clk) begin
    if (!sresetn)
      sel <= IW'(DEFAULT_IMAGE);
    else if (pick && (state == S_COUNT || state == S_HALT))
      sel <= digit[IW-1:0];
  end

  assign image_sel = sel;
`else
  logic unused_data;

  assign unused_data = ^uart_rx_data;
  assign pick        = 1'b0;
  assign image_sel   = IW'(DEFAULT_IMAGE);
`endif

  // Boot sequencing; UART beats the terminal count on the same cycle
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state  <= enable_protection ? S_PROTECT : S_UNPROT;
      halt   <= 1'b0;
      ctr    <= '0;
      reboot <= 1'b0;
      axis_protect_done <= 1'b0;
    end else begin
      unique case (state)
        S_PROTECT: begin
          if (uart_rx_valid) halt <= 1'b1;
          if (hs_last) begin
            axis_protect_done <= 1'b1;
            state <= (halt || uart_rx_valid) ? S_HALT : S_COUNT;
          end
        end
        S_COUNT: begin
          if (pick) begin
            state  <= S_BOOT;
            reboot <= 1'b1;
          end else if (uart_rx_valid) begin
            state <= S_HALT;
            halt  <= 1'b1;
          end else if (ctr == TERM) begin
            state  <= S_BOOT;
            reboot <= 1'b1;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        S_HALT: begin
          if (pick) begin
            state  <= S_BOOT;
            reboot <= 1'b1;
          end
        end
        S_BOOT: reboot <= 1'b1;
        S_UNPROT: begin
          axis_protect_done <= 1'b1;
          ctr <= ctr + 1'b1;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Progress bar thresholds derived from the counter
  always_comb begin
    bar = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      bar[i] = (ctr != '0) && (ctr > CW'(STEP * i));
  end

  // LED bar registered one cycle behind the counter
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      leds <= '0;
    end else begin
      unique case (state)
        S_COUNT, S_HALT: leds <= bar;
        S_BOOT:          leds <= '1;
        S_UNPROT:        leds <= {NUM_LEDS{ctr[BLINK_BIT]}};
        default:         leds <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_multiboot_manager.sv
// tb_multiboot_manager: directed vector table plus hand-written
// sequences for stalls, UART during protection, strap=0 and reset.
module tb_multiboot_manager;

  logic       clk = 1'b0;
  logic       sresetn = 1'b0;
  logic       uart_rx_valid = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       enable_protection = 1'b1;
  logic       reboot;
  logic [1:0] image_sel;
  logic [3:0] leds;
  logic       tready = 1'b0;
  logic       tvalid;
  logic [7:0] tdata;
  logic       done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiboot_manager #(
    .TIMEOUT_CYCLES (100),
    .NUM_LEDS       (4),
    .NUM_IMAGES     (4),
    .DEFAULT_IMAGE  (1),
    .BLINK_BIT      (4)
  ) dut (
    .clk                   (clk),
    .sresetn               (sresetn),
    .uart_rx_valid         (uart_rx_valid),
    .uart_rx_data          (uart_rx_data),
    .enable_protection     (enable_protection),
    .reboot                (reboot),
    .image_sel             (image_sel),
    .leds                  (leds),
    .m_axis_protect_tready (tready),
    .m_axis_protect_tvalid (tvalid),
    .m_axis_protect_tdata  (tdata),
    .axis_protect_done     (done)
  );

  logic [7:0] exp_rom [40] = '{
    8'h57, 8'h00, 8'h00, 8'h00,
    8'h57, 8'h01, 8'h00, 8'hAB,
    8'h57, 8'h00, 8'h00, 8'h03,
    8'h52, 8'h01, 8'hFE,
    8'h57, 8'h00, 8'h00, 8'h00,
    8'h57, 8'h01, 8'h00, 8'h50,
    8'h57, 8'h00, 8'h00, 8'h01,
    8'h57, 8'h00, 8'h00, 8'h00,
    8'h57, 8'h01, 8'h01, 8'h01, 8'h24,
    8'h57, 8'h00, 8'h00, 8'h01
  };

  typedef struct {
    int         u_ctr;
    logic [7:0] b;
    int         rb_at;
    logic [1:0] img;
    logic [3:0] leds;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic strap);
    tready = 1'b0;
    uart_rx_valid = 1'b0;
    enable_protection = strap;
    sresetn = 1'b0;
    step();
    step();
    chk("rst_reboot", 32'(reboot), 0);
    chk("rst_image", 32'(image_sel), 1);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_done", 32'(done), 0);
    sresetn = 1'b1;
  endtask

  task automatic collect(input bit rnd, input int start, input int stop_at,
                         output int n, output bit data_ok,
                         output bit early, output bit tmo);
    bit         stall;
    bit         got_last;
    logic [7:0] prev_d;
    n = start;
    data_ok = 1'b1;
    early = 1'b0;
    tmo = 1'b1;
    stall = 1'b0;
    got_last = 1'b0;
    prev_d = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if (n == stop_at) begin
        tmo = 1'b0;
        tready = 1'b0;
        return;
      end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) early = 1'b1;
      if (stall && (!tvalid || tdata !== prev_d)) data_ok = 1'b0;
      stall = tvalid && !tready;
      prev_d = tdata;
      if (tvalid && tready) begin
        if (n >= 40 || tdata !== exp_rom[n] || tlast_exp(n) !== dut.tlast)
          data_ok = 1'b0;
        got_last = dut.tlast;
        n++;
      end
      step();
      if (got_last) begin
        tmo = 1'b0;
        tready = 1'b0;
        return;
      end
    end
  endtask

  function automatic logic tlast_exp(input int n);
    return (n == 39);
  endfunction

  int  n;
  bit  ok;
  bit  early;
  bit  tmo;
  int  rb_at;
  int  toggles;
  bit  tv_seen;
  bit  unison;
  logic [3:0] l16;
  logic [3:0] l17;
  logic [3:0] l33;

  initial begin
    tbl[0] = '{-1, 8'h00, 100, 2'd1, 4'hF};
    tbl[1] = '{30, 8'h41, -1,  2'd1, 4'h3};
    tbl[2] = '{99, 8'h00, -1,  2'd1, 4'hF};
`ifdef MULTIBOOT_UART_SELECT_EN
    tbl[3] = '{10, 8'h33, 11,  2'd3, 4'hF};
    tbl[4] = '{10, 8'h37, -1,  2'd1, 4'h1};
    tbl[5] = '{0,  8'h30, 1,   2'd0, 4'hF};
`else
    tbl[3] = '{10, 8'h33, -1,  2'd1, 4'h1};
    tbl[4] = '{10, 8'h37, -1,  2'd1, 4'h1};
    tbl[5] = '{0,  8'h30, -1,  2'd1, 4'h0};
`endif

    for (int v = 0; v < 6; v++) begin
      do_reset(1'b1);
      collect(1'b0, 0, -1, n, ok, early, tmo);
      chk($sformatf("v%0d_timeout", v), 32'(tmo), 0);
      chk($sformatf("v%0d_beats", v), n, 40);
      chk($sformatf("v%0d_data", v), 32'(ok), 1);
      chk($sformatf("v%0d_early_done", v), 32'(early), 0);
      chk($sformatf("v%0d_done", v), 32'(done), 1);
      rb_at = -1;
      for (int c = 0; c < 1200; c++) begin
        if (reboot && rb_at < 0) rb_at = c;
        if (c == tbl[v].u_ctr) begin
          uart_rx_valid = 1'b1;
          uart_rx_data = tbl[v].b;
        end
        step();
        uart_rx_valid = 1'b0;
      end
      chk($sformatf("v%0d_reboot_at", v), rb_at, tbl[v].rb_at);
      chk($sformatf("v%0d_image", v), 32'(image_sel), 32'(tbl[v].img));
      chk($sformatf("v%0d_leds", v), 32'(leds), 32'(tbl[v].leds));
    end

    // Random back-pressure: identical stream, done after the last beat
    do_reset(1'b1);
    collect(1'b1, 0, -1, n, ok, early, tmo);
    chk("rnd_timeout", 32'(tmo), 0);
    chk("rnd_beats", n, 40);
    chk("rnd_data", 32'(ok), 1);
    chk("rnd_early_done", 32'(early), 0);
    chk("rnd_done", 32'(done), 1);

    // UART byte during protection halts once the stream completes
    do_reset(1'b1);
    collect(1'b0, 0, 5, n, ok, early, tmo);
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h31;
    step();
    uart_rx_valid = 1'b0;
    collect(1'b0, 5, -1, n, ok, early, tmo);
    chk("pu_beats", n, 40);
    chk("pu_data", 32'(ok), 1);
    rb_at = -1;
    for (int c = 0; c < 300; c++) begin
      if (reboot && rb_at < 0) rb_at = c;
      step();
    end
    chk("pu_reboot", rb_at, -1);
    chk("pu_image", 32'(image_sel), 1);
    chk("pu_leds", 32'(leds), 0);

    // Unprotected strap: no stream, immediate done, blinking bar
    do_reset(1'b0);
    chk("up_done_rel", 32'(done), 0);
    tready = 1'b1;
    tv_seen = 1'b0;
    unison = 1'b1;
    toggles = 0;
    rb_at = -1;
    l16 = 4'h0;
    l17 = 4'h0;
    l33 = 4'h0;
    for (int k = 1; k <= 300; k++) begin
      logic [3:0] prev;
      prev = leds;
      step();
      if (k == 1) chk("up_done", 32'(done), 1);
      if (tvalid) tv_seen = 1'b1;
      if (reboot && rb_at < 0) rb_at = k;
      if (leds != 4'h0 && leds != 4'hF) unison = 1'b0;
      if (leds != prev) toggles++;
      if (k == 16) l16 = leds;
      if (k == 17) l17 = leds;
      if (k == 33) l33 = leds;
    end
    chk("up_tvalid", 32'(tv_seen), 0);
    chk("up_reboot", rb_at, -1);
    chk("up_unison", 32'(unison), 1);
    chk("up_leds_k16", 32'(l16), 32'h0);
    chk("up_leds_k17", 32'(l17), 32'hF);
    chk("up_leds_k33", 32'(l33), 32'h0);
    chk("up_toggles", toggles, 18);

    // One-cycle reset at beat 17 restarts the stream from word 0
    do_reset(1'b1);
    collect(1'b0, 0, 17, n, ok, early, tmo);
    chk("mr_partial", n, 17);
    sresetn = 1'b0;
    step();
    sresetn = 1'b1;
    chk("mr_tvalid", 32'(tvalid), 0);
    chk("mr_done", 32'(done), 0);
    collect(1'b0, 0, -1, n, ok, early, tmo);
    chk("mr_beats", n, 40);
    chk("mr_data", 32'(ok), 1);
    chk("mr_early_done", 32'(early), 0);
    chk("mr_done_after", 32'(done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiboot_manager.md
Name: multiboot_manager

Overview:
- Parametrised successor to the single-image boot manager.
- After reset it streams a flash-protection command sequence into serial_wb_master, then counts down to an automatic warm-boot of a default image.
- UART activity halts the countdown; UART digit bytes can pick one of NUM_IMAGES images.
- A strap selects unprotected (firmware-update) mode, which never protects the flash and never auto-reboots.

Parameters:
- TIMEOUT_CYCLES, 2**27: clk cycles from end of protection to auto-reboot; must be ≥ NUM_LEDS.
- NUM_LEDS, 8: width of the status LED bar.
- NUM_IMAGES, 4: selectable boot images, 1..4 (ICE40 warmboot limit).
- DEFAULT_IMAGE, 1: image booted on timeout; must be < NUM_IMAGES.
- BLINK_BIT, 25: counter bit that drives the LED flash in unprotected mode.

Ports:
- clk  in  1  clock
- sresetn  in  1  reset, synchronous, active-low
- uart_rx_valid  in  1  one-cycle strobe per received UART byte
- uart_rx_data  in  8  received byte, valid with uart_rx_valid
- enable_protection  in  1  strap: 1 = normal mode, 0 = unprotected mode; sampled only during reset
- reboot  out  1  request warmboot; sticky until reset
- image_sel  out  $clog2(NUM_IMAGES) (min 1)  image to boot; stable whenever reboot=1
- leds  out  NUM_LEDS  status display
- m_axis_protect_tready  in  1  AXIS ready from serial_wb_master
- m_axis_protect_tvalid  out  1  AXIS valid
- m_axis_protect_tdata  out  8  AXIS data
- axis_protect_done  out  1  1 = protection finished; UART path owns serial_wb_master

Behaviour:
- Reset (sresetn=0), all outputs:
  - reboot=0, image_sel=DEFAULT_IMAGE, leds=0, tvalid=0, axis_protect_done=0.
  - ctr=0, halt=0.
  - mode latched from enable_protection on every reset cycle.
- States: S_PROTECT, S_COUNT, S_HALT, S_BOOT, S_UNPROT.
- Leaving reset: enable_protection=1 → S_PROTECT; 0 → S_UNPROT.
- S_PROTECT:
  - rom_to_axis streams the fixed sequence: release-from-power-down 0xAB, 255-byte dummy read, volatile WREN 0x50, WRSR1 0x01 with data 0x24 (same frame encoding as the existing sequence).
  - The tvalid&tready&tlast beat moves to S_COUNT; axis_protect_done rises the next cycle and stays 1 until reset.
  - tvalid must not drop without a handshake; tdata must stay stable while stalled.
  - uart_rx_valid here sets halt (latched), so the next state becomes S_HALT instead of S_COUNT.
- S_COUNT:
  - ctr increments every cycle.
  - ctr == TIMEOUT_CYCLES-1 → S_BOOT with image_sel=DEFAULT_IMAGE.
  - uart_rx_valid → S_HALT, ctr frozen.
  - If uart_rx_valid coincides with the terminal count, UART wins: S_HALT, no reboot.
- S_HALT: ctr frozen; stays here until reset unless the optional feature fires.
- S_BOOT:
  - reboot=1 from the cycle after entry, held until reset.
  - image_sel is registered on or before that same cycle.
  - Later UART bytes are ignored.
- S_UNPROT:
  - axis_protect_done=1 the cycle after reset release.
  - tvalid=0 forever; ctr free-runs and wraps; reboot never asserts.
- LEDs (registered, 1-cycle latency from ctr):
  - S_PROTECT: all 0.
  - S_COUNT, S_HALT: leds[i]=1 iff ctr > (TIMEOUT_CYCLES/NUM_LEDS)*i and ctr != 0; frozen bar in S_HALT.
  - S_BOOT: all 1.
  - S_UNPROT: every bit = ctr[BLINK_BIT].
- Counter: width $clog2(TIMEOUT_CYCLES)+1, wide enough to hold BLINK_BIT; unsigned; wraps only in S_UNPROT.
- Reset mid-stream: rom_to_axis restarts from its first word; no partial frame survives.

Optional Feature:
- Macro: MULTIBOOT_UART_SELECT_EN.
- Defined:
  - In S_COUNT or S_HALT, a byte 0x30+k with k < NUM_IMAGES sets image_sel=k and goes to S_BOOT.
  - Any other byte only halts, or is ignored if already halted.
- Undefined:
  - uart_rx_data is unused; any byte only halts.
  - image_sel is constant DEFAULT_IMAGE.

Decomposition:
- Package multiboot_pkg:
  - state enum boot_state_t.
  - protection-sequence localparams: frame opcodes for read/write, config/data register, SS high/low, discard.
  - flash command bytes ASCII_DIGIT0 = 0x30, FLASH_RPD = 0xAB, FLASH_VWREN = 0x50, FLASH_WRSR1 = 0x01, SR1_PROTECT = 0x24.
  - The ROM contents themselves are built from these localparams inside the block.
- Sub-module: the existing rom_to_axis, instantiated once, held in reset unless in S_PROTECT. No new sub-module.

Test Plan:
- TIMEOUT_CYCLES=100, NUM_LEDS=4, strap=1, tready=1, no UART → exactly 40 beats ending in tlast; done=1 the next cycle; reboot=1 at 100+1 cycles after tlast; image_sel=1; leds=4'b1111.
- Same, tready toggling 50% random → tdata sequence identical, no beat lost or duplicated; done after the 40th beat.
- Strap=0 → tvalid never 1; done=1 one cycle after reset; reboot=0 for 2**26 cycles; leds toggle in unison at BLINK_BIT.
- Strap=1, uart_rx_valid at ctr=30 → ctr frozen at 30, leds=4'b0011, reboot stays 0 for 1000 cycles.
- MULTIBOOT_UART_SELECT_EN, byte 0x33 at ctr=10 → reboot=1, image_sel=3; byte 0x37 → halt only; uart_rx_valid on the terminal-count cycle → no reboot.
- Assert sresetn for one cycle mid-protection (beat 17) → stream restarts at beat 0; done=0 until the new tlast.
